// File: rtl/interrupt_pkg.sv
// Shared types and constants for the interrupt entry/ERET sequencer.
// Cause indices follow the CPU's ESR/ECA bit layout.
package interrupt_pkg;

  localparam int unsigned NCAUSE = 23;
  localparam int unsigned IL_W   = 5;
  localparam int unsigned XLEN   = 32;

  localparam int unsigned C_RESET = 0;
  localparam int unsigned C_ILL   = 1;
  localparam int unsigned C_MAL   = 2;
  localparam int unsigned C_PFF   = 3;
  localparam int unsigned C_PFLS  = 4;
  localparam int unsigned C_SYSC  = 5;
  localparam int unsigned C_OVF   = 6;

  localparam int unsigned            P_NMASK     = 7;
  localparam logic [NCAUSE-1:0]      P_RPT_MASK  = 23'h00001F;
  localparam logic [XLEN-1:0]        P_SISR      = 32'h00000000;
  localparam int unsigned            P_DRAIN_MAX = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_SAVE,
    S_JUMP,
    S_RDRAIN,
    S_RESTORE
  } state_t;

  function automatic logic [XLEN-1:0] zext_cause(
    input logic [NCAUSE-1:0] c
  );
    return {{(XLEN-NCAUSE){1'b0}}, c};
  endfunction

endpackage

// File: rtl/interrupt_sequencer_prio_enc23.sv
// Priority encoder over the masked cause vector.
// Lowest index wins; o_any flags a serviceable cause.
module prio_enc23
  import interrupt_pkg::*;
(
  input  logic [NCAUSE-1:0] i_mca,
  output logic [IL_W-1:0]   o_il,
  output logic              o_any
);

  always_comb begin
    o_il = '0;
    for (int i = NCAUSE - 1; i >= 0; i--) begin
      if (i_mca[i]) o_il = IL_W'(i);
    end
  end

  assign o_any = |i_mca;

endmodule

// File: rtl/interrupt_sequencer.sv
// Exception entry / ERET sequencer: drain, save SPRs,
// redirect fetch to the ISR or back to EPC.
module interrupt_sequencer
  import interrupt_pkg::*;
#(
  parameter int unsigned       NMASK     = P_NMASK,
  parameter logic [NCAUSE-1:0] RPT_MASK  = P_RPT_MASK,
  parameter logic [XLEN-1:0]   SISR      = P_SISR,
  parameter int unsigned       DRAIN_MAX = P_DRAIN_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCAUSE-1:0] ca_in,
  input  logic [XLEN-1:0]   sr_in,
  input  logic [XLEN-1:0]   esr_in,
  input  logic [XLEN-1:0]   epc_in,
  input  logic              mode_in,
  input  logic              eret_in,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [XLEN-1:0]   next_pc_in,
  input  logic [XLEN-1:0]   ea_in,
  input  logic              drain_ack,
  input  logic              redirect_ack,
  output logic              stall_req,
  output logic              jisr,
  output logic [IL_W-1:0]   il,
  output logic              sr_we,
  output logic              esr_we,
  output logic              eca_we,
  output logic              epc_we,
  output logic              edata_we,
  output logic [XLEN-1:0]   sr_wdata,
  output logic [XLEN-1:0]   esr_wdata,
  output logic [XLEN-1:0]   eca_wdata,
  output logic [XLEN-1:0]   epc_wdata,
  output logic [XLEN-1:0]   edata_wdata,
  output logic              mode_out,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              busy
);

  localparam logic [NCAUSE-1:0] NM_BITS =
    NCAUSE'((64'd1 << NMASK) - 64'd1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic              r_rphase;
  logic              w_rphase_nxt;
  logic [NCAUSE-1:0] r_mca;
  logic [IL_W-1:0]   r_il;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_npc;
  logic [XLEN-1:0]   r_ea;
  logic [XLEN-1:0]   r_sr;
  logic              r_mode;

  logic [NCAUSE-1:0] w_mca;
  logic [IL_W-1:0]   w_il;
  logic              w_any;
  logic              w_latch;
  logic              w_force;
  logic              w_drained;
  logic              w_save;
  logic              w_rst_wr;
  logic              w_rst_jmp;
  logic              w_jump;

  // Illegal ERET from user mode is folded into the ILL cause.
  always_comb begin
    w_mca = ca_in & (NM_BITS | sr_in[NCAUSE-1:0]);
    w_mca[C_ILL] = w_mca[C_ILL] | (eret_in & mode_in);
  end

  prio_enc23 u_prio (
    .i_mca (w_mca),
    .o_il  (w_il),
    .o_any (w_any)
  );

  assign w_drained = drain_ack ||
                     (r_cnt == 4'(DRAIN_MAX - 1));

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = '0;
    w_rphase_nxt = 1'b0;
    w_latch      = 1'b0;
    w_force      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_latch     = 1'b1;
          w_state_nxt = S_DRAIN;
        end else if (eret_in && !mode_in) begin
          w_state_nxt = S_RDRAIN;
        end
      end
      S_DRAIN: begin
        w_cnt_nxt = r_cnt + 4'd1;
        if (w_drained) w_state_nxt = S_SAVE;
      end
      S_RDRAIN: begin
        w_cnt_nxt = r_cnt + 4'd1;
        if (w_drained) w_state_nxt = S_RESTORE;
      end
      S_SAVE: w_state_nxt = S_JUMP;
      S_JUMP: begin
        if (redirect_ack) w_state_nxt = S_IDLE;
      end
      S_RESTORE: begin
        w_rphase_nxt = 1'b1;
        if (r_rphase && redirect_ack) begin
          w_state_nxt  = S_IDLE;
          w_rphase_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Reset cause pre-empts any in-flight sequence.
    if (ca_in[C_RESET] && r_state != S_IDLE &&
        r_state != S_SAVE) begin
      w_force      = 1'b1;
      w_state_nxt  = S_SAVE;
      w_cnt_nxt    = '0;
      w_rphase_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rphase <= 1'b0;
      r_mca    <= '0;
      r_il     <= '0;
      r_pc     <= '0;
      r_npc    <= '0;
      r_ea     <= '0;
      r_sr     <= '0;
      r_mode   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rphase <= w_rphase_nxt;
      if (w_latch) begin
        r_mca <= w_mca;
        r_il  <= w_il;
        r_pc  <= pc_in;
        r_npc <= next_pc_in;
        r_ea  <= ea_in;
        r_sr  <= sr_in;
      end
      if (w_force) begin
        r_mca <= NCAUSE'(1);
        r_il  <= '0;
      end
      if (w_save) r_mode <= 1'b0;
      if (w_rst_wr) r_mode <= 1'b1;
    end
  end

  assign w_save    = (r_state == S_SAVE);
  assign w_rst_wr  = (r_state == S_RESTORE) && !r_rphase;
  assign w_rst_jmp = (r_state == S_RESTORE) && r_rphase;
  assign w_jump    = (r_state == S_JUMP);

  assign busy      = (r_state != S_IDLE);
  assign stall_req = busy;
  assign jisr      = w_save;
  assign il        = r_il;
  assign mode_out  = r_mode;

  assign sr_we    = w_save | w_rst_wr;
  assign esr_we   = w_save;
  assign eca_we   = w_save;
  assign epc_we   = w_save;
  assign edata_we = w_save;

  assign sr_wdata    = w_rst_wr ? esr_in : '0;
  assign esr_wdata   = w_save ? r_sr : '0;
  assign eca_wdata   = w_save ? zext_cause(r_mca) : '0;
  assign edata_wdata = w_save ? r_ea : '0;
  assign epc_wdata   = !w_save ? '0 :
                       (RPT_MASK[r_il] ? r_pc : r_npc);

  assign redirect_valid = w_jump | w_rst_jmp;
  assign redirect_pc    = w_jump    ? SISR   :
                          w_rst_jmp ? epc_in : '0;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: table vectors, corner
// sequences and randomized transactions vs a rule model.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [22:0] ca_in;
  logic [31:0] sr_in, esr_in, epc_in;
  logic        mode_in, eret_in;
  logic [31:0] pc_in, next_pc_in, ea_in;
  logic        drain_ack, redirect_ack;
  logic        stall_req, jisr;
  logic [4:0]  il;
  logic        sr_we, esr_we, eca_we, epc_we, edata_we;
  logic [31:0] sr_wdata, esr_wdata, eca_wdata;
  logic [31:0] epc_wdata, edata_wdata;
  logic        mode_out, redirect_valid, busy;
  logic [31:0] redirect_pc;

  int n_cmp = 0;
  int n_err = 0;

  localparam int DMAX = 15;

  interrupt_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ca_in          (ca_in),
    .sr_in          (sr_in),
    .esr_in         (esr_in),
    .epc_in         (epc_in),
    .mode_in        (mode_in),
    .eret_in        (eret_in),
    .pc_in          (pc_in),
    .next_pc_in     (next_pc_in),
    .ea_in          (ea_in),
    .drain_ack      (drain_ack),
    .redirect_ack   (redirect_ack),
    .stall_req      (stall_req),
    .jisr           (jisr),
    .il             (il),
    .sr_we          (sr_we),
    .esr_we         (esr_we),
    .eca_we         (eca_we),
    .epc_we         (epc_we),
    .edata_we       (edata_we),
    .sr_wdata       (sr_wdata),
    .esr_wdata      (esr_wdata),
    .eca_wdata      (eca_wdata),
    .epc_wdata      (epc_wdata),
    .edata_wdata    (edata_wdata),
    .mode_out       (mode_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [22:0] ca;
    logic [31:0] sr;
    bit          eret;
    bit          mode;
    int          ack;
    logic [31:0] esr;
    logic [31:0] epc;
    int          kind;
    int          il;
    logic [22:0] mca;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // kind: 0 = ignored, 1 = exception entry, 2 = ERET
  function automatic void model(
    input  logic [22:0] ca,
    input  logic [31:0] sr,
    input  bit          eret,
    input  bit          mode,
    output int          kind,
    output int          idx,
    output logic [22:0] mca
  );
    mca = '0;
    for (int i = 0; i < 23; i++)
      if (ca[i] && (i < 7 || sr[i])) mca[i] = 1'b1;
    if (eret && mode) mca[1] = 1'b1;
    idx = 0;
    for (int i = 22; i >= 0; i--)
      if (mca[i]) idx = i;
    if (mca != 0) kind = 1;
    else if (eret) kind = 2;
    else kind = 0;
  endfunction

  task automatic finish_redirect(input string nm);
    int d;
    d = $urandom_range(0, 2);
    repeat (d) @(negedge clk);
    chk({nm, ".hold_rv"}, 32'(redirect_valid), 1);
    redirect_ack = 1'b1;
    @(negedge clk);
    redirect_ack = 1'b0;
    chk({nm, ".idle"}, 32'(busy), 0);
    chk({nm, ".stall_off"}, 32'(stall_req), 0);
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    logic [31:0] pc, npc, ea, exp_epc;
    int n, exp_n;
    pc  = $urandom;
    npc = pc + 4;
    ea  = $urandom;
    ca_in = v.ca; sr_in = v.sr;
    eret_in = v.eret; mode_in = v.mode;
    pc_in = pc; next_pc_in = npc; ea_in = ea;
    esr_in = v.esr; epc_in = v.epc;
    @(negedge clk);
    ca_in = '0; eret_in = 1'b0;
    pc_in = $urandom; next_pc_in = $urandom;
    ea_in = $urandom; sr_in = $urandom;
    if (v.kind == 0) begin
      chk({nm, ".nobusy"}, 32'(busy), 0);
      @(negedge clk);
      chk({nm, ".nobusy2"}, 32'(busy), 0);
      chk({nm, ".nostall"}, 32'(stall_req), 0);
      return;
    end
    chk({nm, ".stall"}, 32'(stall_req), 1);
    n = 0;
    while (!jisr && !sr_we && n < 40) begin
      drain_ack = (n >= v.ack);
      @(negedge clk);
      n++;
    end
    drain_ack = 1'b0;
    exp_n = (v.ack + 1 < DMAX) ? v.ack + 1 : DMAX;
    chk({nm, ".drain_cycles"}, 32'(n), 32'(exp_n));
    if (v.kind == 1) begin
      exp_epc = (v.il < 5) ? pc : npc;
      chk({nm, ".jisr"}, 32'(jisr), 1);
      chk({nm, ".il"}, 32'(il), 32'(v.il));
      chk({nm, ".eca"}, eca_wdata, 32'(v.mca));
      chk({nm, ".epc"}, epc_wdata, exp_epc);
      chk({nm, ".esr"}, esr_wdata, v.sr);
      chk({nm, ".edata"}, edata_wdata, ea);
      chk({nm, ".sr_wd"}, sr_wdata, 0);
      chk({nm, ".we"}, 32'({sr_we, esr_we, eca_we,
          epc_we, edata_we}), 32'h1F);
      @(negedge clk);
      chk({nm, ".jisr_pulse"}, 32'(jisr), 0);
      chk({nm, ".we_pulse"}, 32'(esr_we | sr_we), 0);
      chk({nm, ".rpc"}, redirect_pc, 32'h0);
      chk({nm, ".mode"}, 32'(mode_out), 0);
      chk({nm, ".jstall"}, 32'(stall_req), 1);
    end else begin
      chk({nm, ".sr_we"}, 32'(sr_we), 1);
      chk({nm, ".sr_wd"}, sr_wdata, v.esr);
      chk({nm, ".no_jisr"}, 32'(jisr | esr_we), 0);
      chk({nm, ".no_rv"}, 32'(redirect_valid), 0);
      @(negedge clk);
      chk({nm, ".mode"}, 32'(mode_out), 1);
      chk({nm, ".sr_we_pulse"}, 32'(sr_we), 0);
      chk({nm, ".rpc"}, redirect_pc, v.epc);
    end
    finish_redirect(nm);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t r;
    logic [31:0] p0;
    rst_n = 1'b0;
    ca_in = '0; sr_in = '0; esr_in = '0; epc_in = '0;
    mode_in = 1'b0; eret_in = 1'b0;
    pc_in = '0; next_pc_in = '0; ea_in = '0;
    drain_ack = 1'b0; redirect_ack = 1'b0;

    tbl[0] = '{23'h20, 0, 0, 0, 3, 0, 0, 1, 5, 23'h20};
    tbl[1] = '{23'h408, 32'h400, 0, 0, 1, 0, 0,
               1, 3, 23'h408};
    tbl[2] = '{23'h400, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 0, 1, 0, 2, 32'h400, 32'h100,
               2, 0, 0};
    tbl[4] = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 23'h2};
    tbl[5] = '{23'h4, 0, 0, 0, 99, 0, 0, 1, 2, 23'h4};
    tbl[6] = '{23'h40, 0, 1, 0, 0, 0, 0, 1, 6, 23'h40};
    tbl[7] = '{23'h400080, 32'h400000, 0, 0, 5, 0, 0,
               1, 22, 23'h400000};
    tbl[8] = '{23'h1, 0, 0, 0, 14, 0, 0, 1, 0, 23'h1};

    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.stall", 32'(stall_req), 0);
    chk("rst.jisr", 32'(jisr), 0);
    chk("rst.il", 32'(il), 0);
    chk("rst.mode", 32'(mode_out), 0);
    chk("rst.rv", 32'(redirect_valid), 0);
    chk("rst.we", 32'({sr_we, esr_we, eca_we,
        epc_we, edata_we}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_txn(tbl[i], $sformatf("tbl%0d", i));

    // reset cause while waiting in JUMP
    p0 = 32'h0000_1230;
    ca_in = 23'h20; pc_in = p0; next_pc_in = p0 + 4;
    @(negedge clk);
    ca_in = '0; drain_ack = 1'b1;
    pc_in = 32'hDEAD_0000;
    @(negedge clk);
    drain_ack = 1'b0;
    chk("jrst.save1", 32'(jisr), 1);
    chk("jrst.epc1", epc_wdata, p0 + 4);
    @(negedge clk);
    chk("jrst.jump", 32'(redirect_valid), 1);
    ca_in = 23'h1;
    @(negedge clk);
    ca_in = '0;
    chk("jrst.save2", 32'(jisr), 1);
    chk("jrst.il", 32'(il), 0);
    chk("jrst.eca", eca_wdata, 32'h1);
    chk("jrst.epc2", epc_wdata, p0);
    @(negedge clk);
    chk("jrst.jump2", 32'(redirect_valid), 1);
    finish_redirect("jrst");

    // async reset while in SAVE
    ca_in = 23'h10;
    @(negedge clk);
    ca_in = '0; drain_ack = 1'b1;
    @(negedge clk);
    drain_ack = 1'b0;
    chk("arst.save", 32'(jisr), 1);
    rst_n = 1'b0;
    #1;
    chk("arst.jisr", 32'(jisr), 0);
    chk("arst.busy", 32'(busy), 0);
    chk("arst.we", 32'({sr_we, esr_we, eca_we,
        epc_we, edata_we}), 0);
    chk("arst.eca", eca_wdata, 0);
    chk("arst.il", 32'(il), 0);
    chk("arst.stall", 32'(stall_req), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst.idle", 32'(busy), 0);

    for (int k = 0; k < 60; k++) begin
      r.ca = 23'($urandom) & 23'($urandom) &
             23'($urandom);
      if ($urandom_range(0, 3) == 0) r.ca = '0;
      r.sr   = $urandom;
      r.eret = ($urandom_range(0, 2) == 0);
      r.mode = $urandom_range(0, 1) == 1;
      r.ack  = $urandom_range(0, 20);
      r.esr  = $urandom;
      r.epc  = $urandom;
      model(r.ca, r.sr, r.eret, r.mode,
            r.kind, r.il, r.mca);
      run_txn(r, $sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Multi-cycle controller that sequences exception entry and ERET for the CPU's interrupt path.
- Samples cause lines, applies SR masking, and priority-encodes the interrupt level.
- Stalls and drains the pipeline, then writes ESR/ECA/EPC/EDATA/SR/mode in one save cycle and redirects fetch to the ISR.
- On ERET, restores SR/mode and redirects to EPC.
- Sits between the cause-collection logic, the SPR file and the fetch stage.

Parameters:
- NCAUSE, 23, number of cause lines.
- NMASK, 7, causes [NMASK-1:0] are non-maskable; cause i >= NMASK is enabled only when sr_in[i]=1.
- RPT_MASK, 23'h00001F, cause bits whose EPC is the repeat PC (pc_in); all others save next_pc_in.
- SISR, 32'h00000000, ISR start address.
- DRAIN_MAX, 15, drain-wait timeout in cycles (4-bit counter).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ca_in  in  NCAUSE  cause lines; level-held by their sources.
- sr_in  in  32  current SR (mask bits).
- esr_in  in  32  current ESR, used on ERET.
- epc_in  in  32  current EPC, used on ERET.
- mode_in  in  1  current mode; 0 = system, 1 = user.
- eret_in  in  1  ERET decoded in execute.
- pc_in  in  32  PC of the faulting instruction.
- next_pc_in  in  32  PC of the next instruction.
- ea_in  in  32  effective address of the current load/store.
- drain_ack  in  1  pipeline empty.
- redirect_ack  in  1  fetch accepted the redirect.
- stall_req  out  1  freeze and drain the pipeline.
- jisr  out  1  one-cycle pulse in SAVE.
- il  out  5  index of the highest-priority serviced cause.
- sr_we, esr_we, eca_we, epc_we, edata_we  out  1 each  SPR write enables.
- sr_wdata, esr_wdata, eca_wdata, epc_wdata, edata_wdata  out  32 each  SPR write data.
- mode_out  out  1  registered mode.
- redirect_valid  out  1  fetch redirect request.
- redirect_pc  out  32  fetch redirect target.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state IDLE; all outputs 0; mode_out=0 (system); internal latches 0.
- Effective causes: mca[i] = ca_in[i] & (i<NMASK | sr_in[i]).
- ERET with mode_in=1 is illegal: it ORs into mca[1] and is not treated as ERET.
- Priority: lowest index wins. il = that index.
- States: IDLE, DRAIN, SAVE, JUMP, RDRAIN, RESTORE.
- IDLE:
  - If |mca: latch mca, il, pc_in, next_pc_in, ea_in, sr_in; go to DRAIN.
  - Else if eret_in & mode_in=0: go to RDRAIN.
  - A cause and an ERET in the same cycle: the cause wins.
- DRAIN/RDRAIN:
  - stall_req=1. Counter counts from 0.
  - Exit on drain_ack, or when the counter reaches DRAIN_MAX. DRAIN exits to SAVE; RDRAIN exits to RESTORE.
  - Timeout proceeds anyway; there is no error flag.
- SAVE (exactly 1 cycle):
  - jisr=1; all five write enables = 1.
  - esr_wdata = latched sr; eca_wdata = zero-extended latched mca.
  - epc_wdata = pc latch if RPT_MASK[il] = 1, else next_pc latch.
  - edata_wdata = ea latch; sr_wdata = 0 (all masked).
  - mode_out <= 0. Go to JUMP.
- JUMP:
  - redirect_valid=1, redirect_pc=SISR, stall_req=1.
  - Hold until redirect_ack, then go to IDLE; stall_req drops in the same cycle.
- RESTORE:
  - Cycle 1: sr_we=1, sr_wdata=esr_in; mode_out <= 1.
  - Next cycle: redirect_valid=1, redirect_pc=epc_in.
  - Hold until redirect_ack, then go to IDLE.
- Reset cause: ca_in[0]=1 in any state other than IDLE/SAVE forces SAVE on the next cycle with mca=1, il=0, skipping the drain. The latched pc/next_pc are kept.
- Causes that fall while busy are lost. Only level-held sources are guaranteed service.
- Write enables are single-cycle pulses. Write data is valid only when the matching enable is high.
- Asynchronous reset mid-sequence: immediate return to the reset state; no partial SPR writes.

Decomposition:
- Shared package interrupt_pkg: state encoding, cause index constants (C_RESET=0, C_ILL=1, C_MAL=2, C_PFF=3, C_PFLS=4, C_SYSC=5, C_OVF=6), NCAUSE.
- Sub-module prio_enc23: priority encoder, mca -> il plus any-valid flag.

Test Plan:
- ca_in bit 5 (sysc) high, drain_ack after 3 cycles:
  - SAVE follows with jisr=1, il=5, eca_wdata=32'h20, epc_wdata=next_pc_in, sr_wdata=0.
  - redirect_pc=SISR; busy clears after redirect_ack.
- ca_in bits 3 and 10 high, sr_in[10]=1: il=3 and epc_wdata=pc_in (repeat cause).
- ca_in bit 10 only, sr_in=0: nothing happens; busy stays 0.
- ERET with mode_in=0, esr_in=32'h400, epc_in=32'h100:
  - sr_we with sr_wdata=32'h400; mode_out=1; redirect_pc=32'h100.
- ERET with mode_in=1: treated as an illegal cause; il=1, eca_wdata bit1=1.
- drain_ack never asserted: SAVE entered exactly DRAIN_MAX cycles after DRAIN entry.
- ca_in[0] pulsed while in JUMP: SAVE on the next cycle with il=0.
- rst_n pulsed low during SAVE: all outputs 0 on the same edge; state returns to IDLE.
